// File: rtl/data_expander_seq.sv
// data_expander_seq: head/lookahead beat queue plus burst-aligned expansion-ratio sequencer.
// Optional counters stat_bursts/stat_stall_cycles exist only when DATA_EXPANDER_SEQ_STATS_EN is defined.
module data_expander_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_COUNT   = 16,
  parameter int TAG_WIDTH  = 1,
  parameter int _CFG_WIDTH = $clog2(CH_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef DATA_EXPANDER_SEQ_STATS_EN
  input  logic                           stat_clr,
  output logic [31:0]                    stat_bursts,
  output logic [31:0]                    stat_stall_cycles,
`endif
  input  logic [_CFG_WIDTH-1:0]          cfg_expand_req,
  input  logic                           cfg_update,
  output logic [_CFG_WIDTH-1:0]          cfg_expand,
  output logic                           cfg_busy,
  input  logic [CH_COUNT*DATA_WIDTH-1:0] s_data,
  input  logic [TAG_WIDTH-1:0]           s_tag,
  input  logic [_CFG_WIDTH-1:0]          s_lccnt,
  input  logic                           s_last,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [CH_COUNT*DATA_WIDTH-1:0] m_data,
  output logic [TAG_WIDTH-1:0]           m_tag,
  output logic [_CFG_WIDTH-1:0]          m_lccnt,
  output logic                           m_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_nxt_valid,
  output logic [_CFG_WIDTH-1:0]          m_nxt_lccnt,
  output logic                           m_nxt_last
);
  localparam int CW = _CFG_WIDTH;
  localparam int PW = TAG_WIDTH + CH_COUNT*DATA_WIDTH;
  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;
  state_t state_q, state_d;
  logic h_vld_q, h_vld_d, l_vld_q, l_vld_d;
  logic [CW:0] h_c_q, h_c_d, l_c_q, l_c_d;
  logic [PW-1:0] h_p_q, h_p_d, l_p_q, l_p_d;
  logic pend_q, pend_d, in_burst_q, in_burst_d;
  logic [CW-1:0] val_q, val_d, exp_q, exp_d;
  logic pop, push, h_from_l, h_from_s, l_from_s, empty, drain_go;
  // slot control {last, lccnt} is reset; payload {tag, data} is not
  always_comb begin
    pop = h_vld_q & m_ready;
    s_ready = (state_q == RUN) & (!l_vld_q | pop);
    push = s_valid & s_ready;
    h_from_l = pop & l_vld_q;
    h_from_s = push & (pop ? !l_vld_q : !h_vld_q);
    l_from_s = push & (pop ? l_vld_q : h_vld_q);
    h_vld_d = h_from_l | h_from_s | (h_vld_q & !pop);
    l_vld_d = l_from_s | (l_vld_q & !pop);
    h_c_d = h_from_l ? l_c_q : h_from_s ? {s_last, s_lccnt} : h_c_q;
    h_p_d = h_from_l ? l_p_q : h_from_s ? {s_tag, s_data} : h_p_q;
    l_c_d = l_from_s ? {s_last, s_lccnt} : l_c_q;
    l_p_d = l_from_s ? {s_tag, s_data} : l_p_q;
    empty = !h_vld_q & !l_vld_q;
    in_burst_d = push ? !s_last : in_burst_q;
    drain_go = (pend_q | cfg_update) & ((push & s_last) | (empty & !in_burst_q));
    val_d = cfg_update ? cfg_expand_req : val_q;
    pend_d = (state_q == APPLY) ? cfg_update : (pend_q | cfg_update);
    exp_d = (state_q == APPLY) ? val_q : exp_q;
    state_d = (state_q == RUN) ? (drain_go ? DRAIN : RUN) :
              (state_q == DRAIN) ? ((empty & m_ready) ? APPLY : DRAIN) : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      h_vld_q <= 1'b0;
      l_vld_q <= 1'b0;
      h_c_q <= '0;
      l_c_q <= '0;
      pend_q <= 1'b0;
      in_burst_q <= 1'b0;
      val_q <= '0;
      exp_q <= '0;
    end else begin
      state_q <= state_d;
      h_vld_q <= h_vld_d;
      l_vld_q <= l_vld_d;
      h_c_q <= h_c_d;
      l_c_q <= l_c_d;
      pend_q <= pend_d;
      in_burst_q <= in_burst_d;
      val_q <= val_d;
      exp_q <= exp_d;
    end
  end
  always_ff @(posedge clk) begin
    h_p_q <= h_p_d;
    l_p_q <= l_p_d;
  end
  assign m_valid = h_vld_q;
  assign {m_last, m_lccnt} = h_c_q;
  assign {m_tag, m_data} = h_p_q;
  assign m_nxt_valid = l_vld_q;
  assign {m_nxt_last, m_nxt_lccnt} = l_c_q;
  assign cfg_expand = exp_q;
  assign cfg_busy = pend_q | (state_q != RUN);
`ifdef DATA_EXPANDER_SEQ_STATS_EN
  logic [31:0] bursts_q, bursts_d, stall_q, stall_d;
  always_comb begin
    bursts_d = stat_clr ? 32'd0 : bursts_q + 32'(push & s_last);
    stall_d = stat_clr ? 32'd0 : stall_q + 32'(s_valid & !s_ready);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bursts_q <= '0;
      stall_q <= '0;
    end else begin
      bursts_q <= bursts_d;
      stall_q <= stall_d;
    end
  end
  assign stat_bursts = bursts_q;
  assign stat_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_data_expander_seq.sv
// tb_data_expander_seq: directed checks of the queue, backpressure, cfg drain/apply sequencing and reset.
module tb_data_expander_seq;
  localparam int DW = 16, CH = 16, TW = 1, CW = 4, BW = DW*CH;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, cfg_update, cfg_busy, s_last, s_valid, s_ready, m_last, m_valid, m_ready, m_nxt_valid, m_nxt_last;
  logic [CW-1:0] cfg_expand_req, cfg_expand, s_lccnt, m_lccnt, m_nxt_lccnt;
  logic [BW-1:0] s_data, m_data;
  logic [TW-1:0] s_tag, m_tag;
`ifdef DATA_EXPANDER_SEQ_STATS_EN
  logic stat_clr = 1'b0;
  logic [31:0] stat_bursts, stat_stall_cycles;
`endif
  int tests = 0, fails = 0;
  data_expander_seq #(.DATA_WIDTH(DW), .CH_COUNT(CH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DATA_EXPANDER_SEQ_STATS_EN
    .stat_clr(stat_clr), .stat_bursts(stat_bursts), .stat_stall_cycles(stat_stall_cycles),
`endif
    .cfg_expand_req(cfg_expand_req), .cfg_update(cfg_update), .cfg_expand(cfg_expand), .cfg_busy(cfg_busy),
    .s_data(s_data), .s_tag(s_tag), .s_lccnt(s_lccnt), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_tag(m_tag), .m_lccnt(m_lccnt), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_nxt_valid(m_nxt_valid), .m_nxt_lccnt(m_nxt_lccnt), .m_nxt_last(m_nxt_last)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; cfg_update = 1'b0; cfg_expand_req = '0;
    s_data = '0; s_tag = '0; s_lccnt = '0; s_last = 1'b0;
    tick; tick;
    @(negedge clk);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %0h want 0", m_valid); end
    tests++; if (m_nxt_valid !== 1'b0) begin fails++; $display("FAIL reset_m_nxt_valid got %0h want 0", m_nxt_valid); end
    tests++; if (m_last !== 1'b0 || m_nxt_last !== 1'b0) begin fails++; $display("FAIL reset_last got %0h/%0h want 0/0", m_last, m_nxt_last); end
    tests++; if (m_lccnt !== 4'd0 || m_nxt_lccnt !== 4'd0) begin fails++; $display("FAIL reset_lccnt got %0h/%0h want 0/0", m_lccnt, m_nxt_lccnt); end
    tests++; if (cfg_expand !== 4'd0) begin fails++; $display("FAIL reset_cfg_expand got %0h want 0", cfg_expand); end
    tests++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL reset_cfg_busy got %0h want 0", cfg_busy); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got %0h want 1", s_ready); end
`ifdef DATA_EXPANDER_SEQ_STATS_EN
    tests++; if (stat_bursts !== 32'd0 || stat_stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stats got %0h/%0h want 0/0", stat_bursts, stat_stall_cycles); end
`endif
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_stream;
    for (int c = 0; c < 12; c++) begin
      s_valid = c < 9; s_data = BW'(c + 1); s_tag = TW'(c); s_last = (c % 3) == 2;
      s_lccnt = s_last ? 4'd5 : 4'd0; m_ready = c >= 2;
      @(negedge clk);
      if (c < 9) begin tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL stream_s_ready c=%0d got %0h want 1", c, s_ready); end end
      if (c == 0 || c == 11) begin tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL stream_empty c=%0d got %0h want 0", c, m_valid); end end
      if (c == 1) begin
        tests++; if (m_valid !== 1'b1 || m_data !== BW'(1) || m_nxt_valid !== 1'b0) begin fails++; $display("FAIL stream_first got v=%0h d=%0h nv=%0h want 1/1/0", m_valid, m_data, m_nxt_valid); end
      end
      if (c >= 2 && c <= 9) begin
        tests++; if (m_valid !== 1'b1 || m_data !== BW'(c - 1)) begin fails++; $display("FAIL stream_head c=%0d got v=%0h d=%0h want 1/%0h", c, m_valid, m_data, c - 1); end
        tests++; if (m_last !== ((c - 2) % 3 == 2)) begin fails++; $display("FAIL stream_last c=%0d got %0h want %0h", c, m_last, (c - 2) % 3 == 2); end
        tests++; if (m_nxt_valid !== 1'b1 || m_nxt_last !== ((c - 1) % 3 == 2) || m_nxt_lccnt !== (((c - 1) % 3 == 2) ? 4'd5 : 4'd0)) begin
          fails++; $display("FAIL stream_nxt c=%0d got v=%0h l=%0h n=%0h", c, m_nxt_valid, m_nxt_last, m_nxt_lccnt); end
      end
      if (c == 10) begin
        tests++; if (m_valid !== 1'b1 || m_data !== BW'(9) || m_last !== 1'b1 || m_lccnt !== 4'd5 || m_nxt_valid !== 1'b0) begin
          fails++; $display("FAIL stream_tail got v=%0h d=%0h l=%0h n=%0h nv=%0h want 1/9/1/5/0", m_valid, m_data, m_last, m_lccnt, m_nxt_valid); end
      end
      tick;
    end
  endtask
  task automatic test_backpressure;
    int sent, got;
    sent = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid = sent < 6; s_data = BW'(16'hA0 + sent); s_tag = TW'(sent); s_last = sent == 5; s_lccnt = '0;
      m_ready = c >= 4;
      @(negedge clk);
      if (c < 2) begin tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL bp_accept c=%0d got %0h want 1", c, s_ready); end end
      if (c == 2 || c == 3) begin tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_full c=%0d got %0h want 0", c, s_ready); end end
      if (m_valid && m_ready) begin
        tests++; if (m_data !== BW'(16'hA0 + got)) begin fails++; $display("FAIL bp_order got %0h want %0h", m_data, 16'hA0 + got); end
        got++;
      end
      if (s_valid && s_ready) sent++;
      tick;
    end
    tests++; if (got !== 6) begin fails++; $display("FAIL bp_count got %0d want 6", got); end
    @(negedge clk);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %0h want 0", m_valid); end
    tick;
  endtask
  task automatic test_cfg_mid;
    logic mr [12] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    logic sr [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    logic bz [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [3:0] ex [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2};
    int b;
    for (int c = 0; c < 12; c++) begin
      b = c < 4 ? c : 4;
      s_valid = c <= 9; s_data = BW'(16'hC0 + b); s_tag = '0; s_last = b >= 3; s_lccnt = '0;
      m_ready = mr[c]; cfg_update = c == 1; cfg_expand_req = 4'd2;
      @(negedge clk);
      if (c < 10) begin tests++; if (s_ready !== sr[c]) begin fails++; $display("FAIL mid_s_ready c=%0d got %0h want %0h", c, s_ready, sr[c]); end end
      tests++; if (cfg_busy !== bz[c]) begin fails++; $display("FAIL mid_busy c=%0d got %0h want %0h", c, cfg_busy, bz[c]); end
      tests++; if (cfg_expand !== ex[c]) begin fails++; $display("FAIL mid_expand c=%0d got %0h want %0h", c, cfg_expand, ex[c]); end
      if (c == 4) begin tests++; if (m_valid !== 1'b1 || m_data !== BW'(16'hC3) || m_last !== 1'b1) begin fails++; $display("FAIL mid_beat4 got v=%0h d=%0h l=%0h", m_valid, m_data, m_last); end end
      if (c == 5) begin tests++; if (m_valid !== 1'b0 || m_nxt_valid !== 1'b0) begin fails++; $display("FAIL mid_drained got %0h/%0h want 0/0", m_valid, m_nxt_valid); end end
      if (c == 10) begin tests++; if (m_valid !== 1'b1 || m_data !== BW'(16'hC4)) begin fails++; $display("FAIL mid_resume got v=%0h d=%0h want 1/c4", m_valid, m_data); end end
      tick;
    end
    cfg_update = 1'b0;
  endtask
  task automatic test_cfg_idle;
    logic bz [5] = '{0, 1, 1, 0, 0};
    logic sr [5] = '{1, 0, 0, 1, 1};
    logic [3:0] ex [5] = '{2, 2, 2, 5, 5};
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b0; m_ready = 1'b1; cfg_update = c == 0; cfg_expand_req = 4'd5;
      @(negedge clk);
      tests++; if (cfg_busy !== bz[c]) begin fails++; $display("FAIL idle_busy c=%0d got %0h want %0h", c, cfg_busy, bz[c]); end
      tests++; if (s_ready !== sr[c]) begin fails++; $display("FAIL idle_s_ready c=%0d got %0h want %0h", c, s_ready, sr[c]); end
      tests++; if (cfg_expand !== ex[c]) begin fails++; $display("FAIL idle_expand c=%0d got %0h want %0h", c, cfg_expand, ex[c]); end
      tick;
    end
    cfg_update = 1'b0;
  endtask
  task automatic test_cfg_overwrite;
    logic bz [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
    logic sr [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic [3:0] ex [9] = '{5, 5, 5, 5, 5, 5, 5, 3, 3};
    for (int c = 0; c < 9; c++) begin
      s_valid = c < 4; s_data = BW'(16'hE0 + c); s_last = c == 3; s_lccnt = '0; m_ready = 1'b1;
      cfg_update = c == 1 || c == 2; cfg_expand_req = c == 1 ? 4'd1 : 4'd3;
      @(negedge clk);
      tests++; if (cfg_busy !== bz[c]) begin fails++; $display("FAIL ow_busy c=%0d got %0h want %0h", c, cfg_busy, bz[c]); end
      tests++; if (s_ready !== sr[c]) begin fails++; $display("FAIL ow_s_ready c=%0d got %0h want %0h", c, s_ready, sr[c]); end
      tests++; if (cfg_expand !== ex[c]) begin fails++; $display("FAIL ow_expand c=%0d got %0h want %0h", c, cfg_expand, ex[c]); end
      tick;
    end
    cfg_update = 1'b0;
  endtask
  task automatic test_reset_mid;
    for (int c = 0; c < 5; c++) begin
      s_valid = c < 3; s_data = BW'(16'hF0 + c); s_last = 1'b0; s_lccnt = 4'd3; m_ready = 1'b0;
      cfg_update = c == 1; cfg_expand_req = 4'd7; rst_n = !(c == 2 || c == 3);
      @(negedge clk);
      if (c == 2) begin
        tests++; if (m_valid !== 1'b1 || m_nxt_valid !== 1'b1 || cfg_busy !== 1'b1 || s_ready !== 1'b0) begin
          fails++; $display("FAIL rstmid_full got v=%0h nv=%0h b=%0h r=%0h want 1/1/1/0", m_valid, m_nxt_valid, cfg_busy, s_ready); end
      end
      if (c >= 3) begin
        tests++; if (m_valid !== 1'b0 || m_nxt_valid !== 1'b0) begin fails++; $display("FAIL rstmid_slots c=%0d got %0h/%0h want 0/0", c, m_valid, m_nxt_valid); end
        tests++; if (cfg_busy !== 1'b0 || cfg_expand !== 4'd0) begin fails++; $display("FAIL rstmid_cfg c=%0d got b=%0h e=%0h want 0/0", c, cfg_busy, cfg_expand); end
      end
      tick;
    end
    rst_n = 1'b1; cfg_update = 1'b0;
  endtask
  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_cfg_mid;
    test_cfg_idle;
    test_cfg_overwrite;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
